// File: rtl/seg_scan_pkg.sv
// Shared constants, segment decoding and FSM state type for the scanned seven-segment display.
// Segment bit 0 is segment a and bit 6 is segment g; a 1 lights the segment.
package seg_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Overflow limit 10^n; evaluated at elaboration time only.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Load/status and display-pin bundle between the result source and the display controller.
interface seg_scan_display_if #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
);
    logic              load;
    logic [WIDTH-1:0]  bin;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [6:0]        hex;
    logic [DIGITS-1:0] dsel;

    modport master (output load, bin, input busy, done, ovf, hex, dsel);
    modport slave  (input load, bin, output busy, done, ovf, hex, dsel);
endinterface

// File: rtl/seg_scan_display_conv.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// The result and captured overflow flag are presented on the final step (o_finish) for the caller to latch.
module bcd_seq_conv
    import seg_scan_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [WIDTH-1:0]    i_bin,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_finish,
    output logic [4*DIGITS-1:0] o_bcd,
    output logic                o_ovf
);
    localparam int          BW    = 4 * DIGITS;
    localparam int          CW    = $clog2(WIDTH + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    conv_state_t    r_state, w_state_next;
    logic [WIDTH-1:0] r_bin;
    logic [BW-1:0]  r_bcd;
    logic [CW-1:0]  r_cnt;
    logic           r_ovf;
    logic           r_done;
    logic           w_capture;
    logic           w_finish;
    logic [BW-1:0]  w_adj;
    logic [BW-1:0]  w_bcd_next;
    logic [WIDTH-1:0] w_bin_next;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                              : r_bcd[gi*4 +: 4];
    end

    assign w_bcd_next = {w_adj[BW-2:0], r_bin[WIDTH-1]};
    assign w_bin_next = r_bin << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_capture) begin
                r_bin <= i_bin;
                r_bcd <= '0;
                r_cnt <= '0;
                r_ovf <= (64'(i_bin) >= LIMIT);
            end else if (r_state == ST_CONV) begin
                r_bin <= w_bin_next;
                r_bcd <= w_bcd_next;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy   = (r_state == ST_CONV);
    assign o_done   = r_done;
    assign o_finish = w_finish;
    assign o_bcd    = w_bcd_next;
    assign o_ovf    = r_ovf;

endmodule

// File: rtl/seg_scan_display.sv
// Multi-digit scanned seven-segment controller: sequential BCD conversion, atomic display register, digit scan.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module seg_scan_display
    import seg_scan_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    seg_scan_display_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic          w_busy, w_done, w_finish, w_ovf_cap;
    logic [BW-1:0] w_bcd_res;
    logic [BW-1:0] r_disp, w_disp_next;
    logic          r_ovf, w_ovf_next;
    logic [PW-1:0] r_pre;
    logic [IW-1:0] r_idx, w_idx_next;
    logic          w_wrap;
    logic [DIGITS-1:0] r_dsel;
    logic [6:0]    r_hex, w_hex_next;
    logic [DIGITS-1:0] w_blank;
    logic [6:0]    w_seg [DIGITS];

    bcd_seq_conv #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk      (clk),
        .rst      (rst),
        .i_load   (bus.load),
        .i_bin    (bus.bin),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_finish (w_finish),
        .o_bcd    (w_bcd_res),
        .o_ovf    (w_ovf_cap)
    );

    // Segments are decoded from the next display state so hex tracks a new value on the edge it lands.
    assign w_disp_next = w_finish ? w_bcd_res : r_disp;
    assign w_ovf_next  = w_finish ? w_ovf_cap : r_ovf;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS:0] w_zero_above;
    assign w_zero_above[DIGITS] = 1'b1;
`endif

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
`ifdef LEADING_ZERO_BLANK_EN
        assign w_zero_above[gi] = (w_disp_next[gi*4 +: 4] == 4'd0) && w_zero_above[gi+1];
        assign w_blank[gi]      = (gi != 0) && w_zero_above[gi];
`else
        assign w_blank[gi]      = 1'b0;
`endif
        assign w_seg[gi] = w_ovf_next  ? SEG_DASH  :
                           w_blank[gi] ? SEG_BLANK : seg_of(w_disp_next[gi*4 +: 4]);
    end

    assign w_wrap     = (r_pre == PW'(SCAN_DIV - 1));
    assign w_idx_next = !w_wrap                   ? r_idx :
                        (r_idx == IW'(DIGITS - 1)) ? '0    : r_idx + 1'b1;

    always_comb begin
        w_hex_next = SEG_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_next == IW'(i)) begin
                w_hex_next = w_seg[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp <= '0;
            r_ovf  <= 1'b0;
            r_pre  <= '0;
            r_idx  <= '0;
            r_dsel <= DIGITS'(1);
            r_hex  <= SEG_0;
        end else begin
            r_disp <= w_disp_next;
            r_ovf  <= w_ovf_next;
            r_pre  <= w_wrap ? '0 : r_pre + 1'b1;
            r_idx  <= w_idx_next;
            r_dsel <= DIGITS'(1) << w_idx_next;
            r_hex  <= w_hex_next;
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.ovf  = r_ovf;
    assign bus.hex  = r_hex;
    assign bus.dsel = r_dsel;

endmodule
